flash_xip_line_buffer: RTL and testbench
========================================

Name: flash_xip_line_buffer

Overview:
- Sits upstream of the SPI APB bridge.
- Takes CPU-side APB reads to the flash window and serves them from a single-line read buffer.
- On a miss, fills the whole line with sequential single-word APB reads into the SPI bridge.
- Non-flash accesses (SPI controller registers) pass straight through, unchanged, one transaction at a time.

Parameters:
- LINE_WORDS, 4, words per line; power of two, 2..16.
- FLASH_BASE, 32'h30000000, flash window base; window size 256 MiB.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_paddr  in  32  upstream APB address
- in_psel  in  1  upstream select
- in_penable  in  1  upstream access phase
- in_pwrite  in  1  upstream write
- in_pwdata  in  32  upstream write data
- in_pstrb  in  4  upstream byte strobes
- in_pready  out  1  upstream ready
- in_prdata  out  32  upstream read data
- in_pslverr  out  1  upstream error
- flush  in  1  one-cycle pulse; invalidates the line
- out_paddr  out  32  downstream address
- out_psel  out  1  downstream select
- out_penable  out  1  downstream access phase
- out_pwrite  out  1  downstream write
- out_pwdata  out  32  downstream write data
- out_pstrb  out  4  downstream strobes
- out_pready  in  1  downstream ready
- out_prdata  in  32  downstream read data
- out_pslverr  in  1  downstream error

Behaviour:
- Reset values:
  - line_valid=0.
  - All out_* = 0.
  - in_pready=0, in_prdata=0, in_pslverr=0.
  - State IDLE.
- Flash hit test: in_paddr[31:28]==FLASH_BASE[31:28].
  - Tag = in_paddr[27:log2(LINE_WORDS)+2].
  - Word index = in_paddr[log2(LINE_WORDS)+1:2].
- States: IDLE, PASS_SETUP, PASS_ACCESS, FILL_SETUP, FILL_ACCESS, RESP.
- IDLE, entered on in_psel&&!in_penable:
  - Non-flash access → PASS_SETUP.
  - Flash write → RESP with in_pslverr=1. No downstream traffic, line untouched.
  - Flash read, hit (valid && tag match) → RESP with buffered word.
  - Flash read, miss → FILL_SETUP. Fill counter = 0, line_valid=0, tag latched.
- PASS_SETUP:
  - Drive out_* = latched upstream fields, out_psel=1, out_penable=0.
  - → PASS_ACCESS.
- PASS_ACCESS:
  - out_penable=1; hold until out_pready.
  - Capture prdata/pslverr, drop out_psel/out_penable the same edge, → RESP.
- FILL_SETUP:
  - out_paddr = {tag, counter, 2'b00} | FLASH_BASE window.
  - out_pwrite=0, out_pstrb=4'hf, out_psel=1, out_penable=0.
- FILL_ACCESS:
  - out_penable=1 until out_pready.
  - On ready: store out_prdata into word[counter]; OR out_pslverr into err flag; deassert psel/penable.
  - If counter==LINE_WORDS-1 → RESP; else increment counter → FILL_SETUP.
  - Every beat therefore has ≥1 cycle with penable low, as the SPI bridge requires.
- RESP:
  - in_pready=1 for exactly one cycle.
  - in_prdata = requested word (or passthrough data).
  - in_pslverr = error flag.
  - line_valid = !err after a fill.
  - → IDLE.
- in_pready is registered; upstream must hold the request until it sees it.
- Hit latency: in_pready 2 cycles after setup.
- Miss latency: 2 + LINE_WORDS×(2 + downstream wait) cycles.
- Upstream abort (in_psel drops before RESP):
  - Fill completes.
  - Response is suppressed, no in_pready.
  - Line still validated.
- flush:
  - In IDLE/RESP, clears line_valid next edge.
  - During a fill, sets a pending flag; the completed line is not validated.
- Reset mid-fill: downstream select drops next cycle; line invalid.
- Only one transaction is outstanding; no pipelining.

Optional Feature:
- Macro XIP_PERF_CNT_EN.
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0]:
  - Increment on each flash read decision in IDLE.
  - Wrap at 2^32.
  - Cleared by reset, not by flush.
- When undefined: ports absent, no counter logic.

Test Plan:
- Reset, then read 0x30000008:
  - 4 downstream reads: 0x30000000, 0x30000004, 0x30000008, 0x3000000C.
  - in_prdata = word returned for 0x30000008.
- Then read 0x30000004: hit, zero downstream traffic, in_pready 2 cycles after setup, data matches fill beat 1.
- Read 0x10000010 (SPI reg): single passthrough; out_paddr=0x10000010, pwrite/pstrb/pwdata forwarded.
  - Write 0x10000014 data 0x2: forwarded verbatim.
- Write to 0x30000000: in_pslverr=1, no out_psel; a subsequent hit read still returns cached data.
- out_pslverr=1 on beat 2 of a fill: response in_pslverr=1; next read to the same line re-fills (4 beats).
- flush asserted during a fill: response returns data; the following read to the same address misses again.
  - With XIP_PERF_CNT_EN: miss_cnt=2, hit_cnt=0.

Source files
------------

// File: rtl/flash_xip_line_buffer.sv
// flash_xip_line_buffer: single-line read buffer for the flash XIP window,
// placed upstream of the SPI APB bridge. Flash reads hit the line or refill it
// with sequential single-word downstream reads. Everything else passes through.
// Optional build macro XIP_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module flash_xip_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        flush,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
`ifdef XIP_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 26 - IDX_W;

  typedef enum logic [2:0] {
    IDLE, PASS_SETUP, PASS_ACCESS, FILL_SETUP, FILL_ACCESS, RESP
  } state_t;

  state_t state_q, state_d;

  logic             line_valid_q, line_valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fill_q, fill_d;
  logic             flush_pend_q, flush_pend_d;
  logic             abort_q, abort_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      line_q [LINE_WORDS];
  logic [31:0]      line_d [LINE_WORDS];

  logic [31:0] out_paddr_q, out_paddr_d;
  logic        out_psel_q, out_psel_d;
  logic        out_penable_q, out_penable_d;
  logic        out_pwrite_q, out_pwrite_d;
  logic [31:0] out_pwdata_q, out_pwdata_d;
  logic [3:0]  out_pstrb_q, out_pstrb_d;
  logic        in_pready_q, in_pready_d;
  logic [31:0] in_prdata_q, in_prdata_d;
  logic        in_pslverr_q, in_pslverr_d;

  logic             req_start;
  logic             req_flash;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_hit;
  logic             cnt_last;
  logic             resp_ok;

  // Request decode; a flush in the same cycle forces a miss
  assign req_start = in_psel && !in_penable;
  assign req_flash = in_paddr[31:28] == FLASH_BASE[31:28];
  assign req_tag   = in_paddr[27:IDX_W+2];
  assign req_idx   = in_paddr[IDX_W+1:2];
  assign req_hit   = line_valid_q && (tag_q == req_tag) && !flush;
  assign cnt_last  = cnt_q == IDX_W'(LINE_WORDS - 1);
  assign resp_ok   = in_psel && !abort_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_start) begin
          if (!req_flash)                state_d = PASS_SETUP;
          else if (in_pwrite || req_hit) state_d = RESP;
          else                           state_d = FILL_SETUP;
        end
      end
      PASS_SETUP:  state_d = PASS_ACCESS;
      PASS_ACCESS: if (out_pready) state_d = RESP;
      FILL_SETUP:  state_d = FILL_ACCESS;
      FILL_ACCESS: if (out_pready) state_d = cnt_last ? RESP : FILL_SETUP;
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output logic: downstream flops track the state being entered, upstream
  // response flops are loaded from RESP so in_pready lasts one cycle
  always_comb begin
    out_paddr_d   = out_paddr_q;
    out_pwrite_d  = out_pwrite_q;
    out_pwdata_d  = out_pwdata_q;
    out_pstrb_d   = out_pstrb_q;
    out_psel_d    = 1'b0;
    out_penable_d = 1'b0;
    in_pready_d   = 1'b0;
    in_prdata_d   = '0;
    in_pslverr_d  = 1'b0;
    case (state_d)
      PASS_SETUP: begin
        out_psel_d   = 1'b1;
        out_paddr_d  = in_paddr;
        out_pwrite_d = in_pwrite;
        out_pwdata_d = in_pwdata;
        out_pstrb_d  = in_pstrb;
      end
      FILL_SETUP: begin
        out_psel_d   = 1'b1;
        out_paddr_d  = {FLASH_BASE[31:28], tag_d, cnt_d, 2'b00};
        out_pwrite_d = 1'b0;
        out_pwdata_d = '0;
        out_pstrb_d  = 4'hf;
      end
      PASS_ACCESS, FILL_ACCESS: begin
        out_psel_d    = 1'b1;
        out_penable_d = 1'b1;
      end
      default: ;
    endcase
    if (state_q == RESP && resp_ok) begin
      in_pready_d  = 1'b1;
      in_prdata_d  = rdata_q;
      in_pslverr_d = err_q;
    end
  end

  // Line bookkeeping, fill beats, response data and flush/abort tracking
  always_comb begin
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    abort_d      = abort_q;
    rdata_d      = rdata_q;
    line_d       = line_q;
    if (state_q != IDLE && !in_psel) abort_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (flush) line_valid_d = 1'b0;
        if (req_start) begin
          abort_d      = 1'b0;
          flush_pend_d = 1'b0;
          fill_d       = 1'b0;
          err_d        = req_flash && in_pwrite;
          idx_d        = req_idx;
          rdata_d      = line_q[req_idx];
          if (req_flash && !in_pwrite && !req_hit) begin
            tag_d        = req_tag;
            cnt_d        = '0;
            line_valid_d = 1'b0;
            fill_d       = 1'b1;
          end
        end
      end
      PASS_SETUP: begin
        if (flush) line_valid_d = 1'b0;
      end
      PASS_ACCESS: begin
        if (flush) line_valid_d = 1'b0;
        if (out_pready) begin
          rdata_d = out_prdata;
          err_d   = out_pslverr;
        end
      end
      FILL_SETUP: begin
        if (flush) flush_pend_d = 1'b1;
      end
      FILL_ACCESS: begin
        if (flush) flush_pend_d = 1'b1;
        if (out_pready) begin
          line_d[cnt_q] = out_prdata;
          err_d         = err_q | out_pslverr;
          if (cnt_q == idx_q) rdata_d = out_prdata;
          if (!cnt_last) cnt_d = cnt_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (fill_q)     line_valid_d = !err_q && !flush_pend_q && !flush;
        else if (flush) line_valid_d = 1'b0;
        fill_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid_q  <= 1'b0;
      tag_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      fill_q        <= 1'b0;
      flush_pend_q  <= 1'b0;
      abort_q       <= 1'b0;
      rdata_q       <= '0;
      out_paddr_q   <= '0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      out_pwrite_q  <= 1'b0;
      out_pwdata_q  <= '0;
      out_pstrb_q   <= '0;
      in_pready_q   <= 1'b0;
      in_prdata_q   <= '0;
      in_pslverr_q  <= 1'b0;
    end else begin
      line_valid_q  <= line_valid_d;
      tag_q         <= tag_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      fill_q        <= fill_d;
      flush_pend_q  <= flush_pend_d;
      abort_q       <= abort_d;
      rdata_q       <= rdata_d;
      out_paddr_q   <= out_paddr_d;
      out_psel_q    <= out_psel_d;
      out_penable_q <= out_penable_d;
      out_pwrite_q  <= out_pwrite_d;
      out_pwdata_q  <= out_pwdata_d;
      out_pstrb_q   <= out_pstrb_d;
      in_pready_q   <= in_pready_d;
      in_prdata_q   <= in_prdata_d;
      in_pslverr_q  <= in_pslverr_d;
    end
  end

  // Line data storage; contents only matter while line_valid is set
  always_ff @(posedge clock) begin
    line_q <= line_d;
  end

  assign out_paddr   = out_paddr_q;
  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_pwrite  = out_pwrite_q;
  assign out_pwdata  = out_pwdata_q;
  assign out_pstrb   = out_pstrb_q;
  assign in_pready   = in_pready_q;
  assign in_prdata   = in_prdata_q;
  assign in_pslverr  = in_pslverr_q;

`ifdef XIP_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Count every flash read hit/miss decision taken in IDLE
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && req_start && req_flash && !in_pwrite) begin
      if (req_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else         miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_flash_xip_line_buffer.sv
// Testbench for flash_xip_line_buffer: table of upstream transactions plus
// hand-written sequences for error fill, abort, reset mid-fill and flush.
module tb_flash_xip_line_buffer;

  localparam int K_HIT  = 0;
  localparam int K_FILL = 1;
  localparam int K_PASS = 2;
  localparam int K_FERR = 3;
  localparam int NVEC   = 14;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        flush;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;
`ifdef XIP_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          kind;
    int          wait_cycles;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } dn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } rsp_t;

  vec_t        vecs [NVEC];
  dn_t         dn_seen [$];
  dn_t         exp_dn [$];
  rsp_t        exp_rsp [$];
  int          dn_rd;
  int          checks;
  int          errors;
  int          wait_cfg;
  logic        err_en;
  logic [31:0] err_addr;
  int          s_wait;

  flash_xip_line_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_penable  (in_penable),
    .in_pwrite   (in_pwrite),
    .in_pwdata   (in_pwdata),
    .in_pstrb    (in_pstrb),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .flush       (flush),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr)
`ifdef XIP_PERF_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Downstream slave: configurable wait states, optional error on one address
  always @(negedge clock) begin
    if (reset || !(out_psel && out_penable)) begin
      out_pready  = 1'b0;
      out_pslverr = 1'b0;
      s_wait      = 0;
    end else if (s_wait == wait_cfg) begin
      out_pready  = 1'b1;
      out_prdata  = slave_data(out_paddr);
      out_pslverr = err_en && (out_paddr == err_addr);
      dn_seen.push_back('{out_paddr, out_pwrite, out_pwdata, out_pstrb});
      s_wait      = s_wait + 1;
    end else begin
      out_pready  = 1'b0;
      out_pslverr = 1'b0;
      s_wait      = s_wait + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_dn(input string tag);
    int  n_obs;
    dn_t e;
    dn_t o;
    n_obs = dn_seen.size() - dn_rd;
    chk({tag, " beats"}, 32'(n_obs), 32'(exp_dn.size()));
    while (exp_dn.size() > 0) begin
      e = exp_dn.pop_front();
      if (dn_rd < dn_seen.size()) begin
        o = dn_seen[dn_rd];
        dn_rd++;
        chk({tag, " out_paddr"}, o.addr, e.addr);
        chk({tag, " out_pwrite"}, 32'(o.write), 32'(e.write));
        chk({tag, " out_pstrb"}, 32'(o.strb), 32'(e.strb));
        if (e.write) chk({tag, " out_pwdata"}, o.wdata, e.wdata);
      end
    end
    dn_rd = dn_seen.size();
  endtask

  task automatic push_fill(input logic [31:0] addr);
    for (int i = 0; i < 4; i++)
      exp_dn.push_back('{(addr & ~32'hF) + 32'(4 * i), 1'b0, 32'h0, 4'hf});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    int          exp_lat;
    bit          got;
    logic [31:0] rd;
    logic        re;
    rsp_t        r;
    wait_cfg = v.wait_cycles;
    if (v.kind == K_FILL)      push_fill(v.addr);
    else if (v.kind == K_PASS) exp_dn.push_back('{v.addr, v.write, v.wdata, v.strb});
    exp_rsp.push_back('{slave_data(v.addr), v.exp_err, v.kind != K_FERR});
    case (v.kind)
      K_FILL:  exp_lat = 2 + 4 * (2 + v.wait_cycles);
      K_PASS:  exp_lat = 4 + v.wait_cycles;
      default: exp_lat = 2;
    endcase
    @(posedge clock); #1;
    in_paddr = v.addr; in_pwrite = v.write; in_pwdata = v.wdata; in_pstrb = v.strb;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    lat = 0; got = 1'b0; rd = '0; re = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clock);
      lat++;
      if (in_pready) begin
        got = 1'b1; rd = in_prdata; re = in_pslverr;
      end
    end
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0;
    r = exp_rsp.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no in_pready within %0d cycles", tag, lat);
    end else begin
      if (r.chk_data) chk({tag, " in_prdata"}, rd, r.data);
      chk({tag, " in_pslverr"}, 32'(re), 32'(r.err));
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    end
    check_dn(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    in_pwdata = '0; in_pstrb = '0; flush = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst out_psel", 32'(out_psel), 32'h0);
    chk("rst out_penable", 32'(out_penable), 32'h0);
    chk("rst out_paddr", out_paddr, 32'h0);
    chk("rst out_pwrite", 32'(out_pwrite), 32'h0);
    chk("rst out_pstrb", 32'(out_pstrb), 32'h0);
    chk("rst in_pready", 32'(in_pready), 32'h0);
    chk("rst in_prdata", in_prdata, 32'h0);
    chk("rst in_pslverr", 32'(in_pslverr), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    dn_rd = dn_seen.size();
    exp_dn.delete();
  endtask

  initial begin
    int rdy_seen;
    checks = 0; errors = 0; dn_rd = 0;
    wait_cfg = 0; err_en = 1'b0; err_addr = '0;

    vecs[0]  = '{32'h3000_0008, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0};
    vecs[1]  = '{32'h3000_0004, 1'b0, 32'h0, 4'hf, K_HIT,  0, 1'b0};
    vecs[2]  = '{32'h1000_0010, 1'b0, 32'h0, 4'h0, K_PASS, 0, 1'b0};
    vecs[3]  = '{32'h1000_0014, 1'b1, 32'h2, 4'hf, K_PASS, 1, 1'b0};
    vecs[4]  = '{32'h3000_0000, 1'b1, 32'h1234_5678, 4'hf, K_FERR, 0, 1'b1};
    vecs[5]  = '{32'h3000_000C, 1'b0, 32'h0, 4'hf, K_HIT,  0, 1'b0};
    vecs[6]  = '{32'h3000_0010, 1'b0, 32'h0, 4'hf, K_FILL, 2, 1'b0};
    vecs[7]  = '{32'h3000_0014, 1'b0, 32'h0, 4'hf, K_HIT,  0, 1'b0};
    vecs[8]  = '{32'h3000_0000, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0};
    vecs[9]  = '{32'h3FFF_FFFC, 1'b0, 32'h0, 4'hf, K_FILL, 1, 1'b0};
    vecs[10] = '{32'h3FFF_FFF0, 1'b0, 32'h0, 4'hf, K_HIT,  0, 1'b0};
    vecs[11] = '{32'h2000_0000, 1'b0, 32'h0, 4'h0, K_PASS, 0, 1'b0};
    vecs[12] = '{32'h4000_0000, 1'b1, 32'hA5A5_0F0F, 4'h5, K_PASS, 0, 1'b0};
    vecs[13] = '{32'h3000_0008, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0};

    do_reset();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Error on the third fill beat: response errs, line stays invalid
    err_en = 1'b1; err_addr = 32'h3000_0048;
    run_vec('{32'h3000_0044, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b1}, "errfill");
    err_en = 1'b0;
    run_vec('{32'h3000_0044, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0}, "errrefill");
    run_vec('{32'h3000_004C, 1'b0, 32'h0, 4'hf, K_HIT, 0, 1'b0}, "errhit");

    // Upstream abort mid-fill: fill completes silently, line still validated
    wait_cfg = 0;
    push_fill(32'h3000_0080);
    @(posedge clock); #1;
    in_paddr = 32'h3000_0080; in_pwrite = 1'b0; in_pstrb = 4'hf;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    in_psel = 1'b0; in_penable = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (in_pready) rdy_seen++;
    end
    chk("abort in_pready", 32'(rdy_seen), 32'h0);
    check_dn("abort");
    run_vec('{32'h3000_0084, 1'b0, 32'h0, 4'hf, K_HIT, 0, 1'b0}, "aborthit");

    // Reset in the middle of a fill
    @(posedge clock); #1;
    in_paddr = 32'h3000_00C0; in_pwrite = 1'b0; in_pstrb = 4'hf;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("midfill out_psel", 32'(out_psel), 32'h1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rstfill out_psel", 32'(out_psel), 32'h0);
    chk("rstfill out_penable", 32'(out_penable), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; in_psel = 1'b0; in_penable = 1'b0;
    repeat (2) @(posedge clock);
    dn_rd = dn_seen.size();
    exp_dn.delete();
    run_vec('{32'h3000_00C4, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0}, "rstrefill");

    // Flush during a fill: data returned, line not validated
    do_reset();
    fork
      run_vec('{32'h3000_0008, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0}, "flushfill");
      begin
        repeat (4) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
      end
    join
    run_vec('{32'h3000_0008, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0}, "flushmiss");
`ifdef XIP_PERF_CNT_EN
    chk("perf miss_cnt", miss_cnt, 32'd2);
    chk("perf hit_cnt", hit_cnt, 32'd0);
`endif

    // Flush while idle invalidates a valid line
    run_vec('{32'h3000_000C, 1'b0, 32'h0, 4'hf, K_HIT, 0, 1'b0}, "prefluhit");
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    run_vec('{32'h3000_000C, 1'b0, 32'h0, 4'hf, K_FILL, 0, 1'b0}, "idleflush");
`ifdef XIP_PERF_CNT_EN
    chk("perf miss_cnt end", miss_cnt, 32'd3);
    chk("perf hit_cnt end", hit_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
